dmem_port_arbiter: RTL and testbench

//  Shares BRAM port B (data memory) between two masters: the CPU control FSM
//  (cpu_*) and a debug/loader master (dbg_*, memory display scanner or

---
 rtl/dmem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port B arbiter: CPU has fixed priority, the debug/loader master may lock the port
// for bursts, and the CPU can break a lock once it has been kept waiting for STARVE_MAX cycles.
module dmem_port_arbiter #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 9,
   parameter int STARVE_MAX = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic              dbg_lock,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              locked
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   localparam logic [0:0] ST_NORMAL = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]        r_state;
   logic [SW-1:0]     r_starve_cnt;
   logic              r_cpu_gnt;
   logic              r_dbg_gnt;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_din;
   logic              r_cpu_rvalid;
   logic              r_dbg_rvalid;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dbg_rdata;

   logic              w_cpu_elig;
   logic              w_dbg_elig;
   logic              w_lock_held;
   logic              w_starved;
   logic              w_cpu_win;
   logic              w_dbg_win;
   logic [0:0]        w_state_nxt;
   logic [SW-1:0]     w_cnt_nxt;

   // A master granted this cycle still shows req; it must not be re-granted at once.
   assign w_cpu_elig  = cpu_req & ~r_cpu_gnt;
   assign w_dbg_elig  = dbg_req & ~r_dbg_gnt;
   assign w_lock_held = (r_state == ST_LOCKED) & dbg_lock;
   assign w_starved   = (r_starve_cnt == SW'(STARVE_MAX));

   always_comb begin
      w_cpu_win   = 1'b0;
      w_dbg_win   = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_starve_cnt;
      if (w_lock_held) begin
         if (w_cpu_elig && w_starved) begin
            w_cpu_win = 1'b1;
         end else begin
            w_dbg_win = w_dbg_elig;
         end
         if (w_cpu_win || !cpu_req) begin
            w_cnt_nxt = '0;
         end else if (!r_cpu_gnt && !w_starved) begin
            w_cnt_nxt = r_starve_cnt + 1'b1;
         end
      end else begin
         // Dropping dbg_lock while LOCKED is arbitrated exactly like NORMAL.
         if (w_cpu_elig) begin
            w_cpu_win = 1'b1;
         end else begin
            w_dbg_win = w_dbg_elig;
         end
         w_state_nxt = (w_dbg_win && dbg_lock) ? ST_LOCKED : ST_NORMAL;
         w_cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_NORMAL;
         r_starve_cnt <= '0;
         r_cpu_gnt    <= 1'b0;
         r_dbg_gnt    <= 1'b0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_din    <= '0;
         r_cpu_rvalid <= 1'b0;
         r_dbg_rvalid <= 1'b0;
         r_cpu_rdata  <= '0;
         r_dbg_rdata  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_cnt_nxt;
         r_cpu_gnt    <= w_cpu_win;
         r_dbg_gnt    <= w_dbg_win;
         r_mem_en     <= w_cpu_win | w_dbg_win;
         r_mem_we     <= (w_cpu_win & cpu_we) | (w_dbg_win & dbg_we);
         if (w_cpu_win) begin
            r_mem_addr <= cpu_addr;
            r_mem_din  <= cpu_wdata;
         end else if (w_dbg_win) begin
            r_mem_addr <= dbg_addr;
            r_mem_din  <= dbg_wdata;
         end
         // The grant pulse doubles as the owner tag for the read returning next cycle.
         r_cpu_rvalid <= r_cpu_gnt & ~r_mem_we;
         r_dbg_rvalid <= r_dbg_gnt & ~r_mem_we;
         if (r_cpu_rvalid) begin
            r_cpu_rdata <= mem_dout;
         end
         if (r_dbg_rvalid) begin
            r_dbg_rdata <= mem_dout;
         end
      end
   end

   assign cpu_gnt    = r_cpu_gnt;
   assign dbg_gnt    = r_dbg_gnt;
   assign cpu_rvalid = r_cpu_rvalid;
   assign dbg_rvalid = r_dbg_rvalid;
   assign cpu_rdata  = r_cpu_rvalid ? mem_dout : r_cpu_rdata;
   assign dbg_rdata  = r_dbg_rvalid ? mem_dout : r_dbg_rdata;
   assign mem_en     = r_mem_en;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_din    = r_mem_din;
   assign locked     = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural BRAM on port B.
module tb_dmem_port_arbiter;

   localparam int DW = 16;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata, dbg_wdata;
   logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic          mem_en, mem_we, locked;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .locked(locked)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_din;
         else        mem_dout      <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_gl(input string tag, input logic cg, input logic dg, input logic lk);
      check({tag, "_cpu_gnt"}, cpu_gnt, cg);
      check({tag, "_dbg_gnt"}, dbg_gnt, dg);
      check({tag, "_locked"},  locked,  lk);
   endtask

   task automatic chk_all_zero(input string tag);
      check({tag, "_flags"}, {cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, locked}, 0);
      check({tag, "_addr"},  mem_addr,  0);
      check({tag, "_din"},   mem_din,   0);
      check({tag, "_crd"},   cpu_rdata, 0);
      check({tag, "_drd"},   dbg_rdata, 0);
   endtask

   task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_dbg(input logic req, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic lk);
      dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_lock = lk;
   endtask

   logic [11:0] cpu_pat, dbg_pat;

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[9'h012] = 16'hBEEF;
      mem[9'h020] = 16'h1111;
      mem[9'h030] = 16'h2222;
      mem_dout = '0;
      rst_n = 1'b0;
      set_cpu(0, 0, 0, 0);
      set_dbg(0, 0, 0, 0, 0);

      // 1: reset with random inputs
      for (int i = 0; i < 3; i++) begin
         set_cpu(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
         set_dbg(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom));
         step();
         chk_all_zero("rst");
      end
      set_cpu(0, 0, 0, 0);
      set_dbg(0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step();
      chk_all_zero("idle");

      // 2: single CPU read
      set_cpu(1, 0, 9'h012, 0);
      step();
      chk_gl("t2_t1", 1, 0, 0);
      check("t2_en", mem_en, 1);
      check("t2_we", mem_we, 0);
      check("t2_addr", mem_addr, 9'h012);
      set_cpu(0, 0, 0, 0);
      step();
      check("t2_crv", cpu_rvalid, 1);
      check("t2_crd", cpu_rdata, 16'hBEEF);
      check("t2_drv", dbg_rvalid, 0);
      check("t2_en2", mem_en, 0);
      step();
      check("t2_crv_off", cpu_rvalid, 0);
      check("t2_hold", cpu_rdata, 16'hBEEF);

      // 3: both masters reading, interleaved grants
      set_cpu(1, 0, 9'h020, 0);
      set_dbg(1, 0, 9'h030, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk_gl($sformatf("t3_c%0d", i), logic'(i % 2 == 1), logic'(i % 2 == 0), 0);
         check($sformatf("t3_crv%0d", i), cpu_rvalid, logic'(i % 2 == 0));
         check($sformatf("t3_drv%0d", i), dbg_rvalid, logic'(i % 2 == 1 && i >= 3));
         if (i % 2 == 0) check($sformatf("t3_crd%0d", i), cpu_rdata, 16'h1111);
         if (i == 3)     check("t3_drd3", dbg_rdata, 16'h2222);
      end
      set_cpu(0, 0, 0, 0);
      set_dbg(0, 0, 0, 0, 0);
      step();
      chk_gl("t3_c5", 0, 0, 0);
      check("t3_drv5", dbg_rvalid, 1);
      check("t3_drd5", dbg_rdata, 16'h2222);
      step();

      // 4: locked dbg write burst, CPU waits until lock drops
      set_dbg(1, 1, 9'h100, 16'h00A0, 1);
      step();
      chk_gl("t4_s1", 0, 1, 1);
      check("t4_s1_we", mem_we, 1);
      check("t4_s1_addr", mem_addr, 9'h100);
      set_dbg(1, 1, 9'h101, 16'h00A1, 1);
      step(); chk_gl("t4_s2", 0, 0, 1);
      check("t4_s2_drv", dbg_rvalid, 0);
      step(); chk_gl("t4_s3", 0, 1, 1);
      check("t4_s3_addr", mem_addr, 9'h101);
      set_dbg(1, 1, 9'h102, 16'h00A2, 1);
      set_cpu(1, 0, 9'h101, 0);
      step(); chk_gl("t4_s4", 0, 0, 1);
      step(); chk_gl("t4_s5", 0, 1, 1);
      set_dbg(1, 1, 9'h103, 16'h00A3, 1);
      step(); chk_gl("t4_s6", 0, 0, 1);
      step(); chk_gl("t4_s7", 0, 1, 1);
      check("t4_s7_addr", mem_addr, 9'h103);
      set_dbg(0, 0, 0, 0, 0);
      step(); chk_gl("t4_s8", 1, 0, 0);
      check("t4_s8_addr", mem_addr, 9'h101);
      check("t4_s8_we", mem_we, 0);
      set_cpu(0, 0, 0, 0);
      step();
      check("t4_crv", cpu_rvalid, 1);
      check("t4_crd", cpu_rdata, 16'h00A1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t4_mem%0d", i), mem[9'h100 + i], 16'h00A0 + i);
      end
      step();

      // 5: starvation break with STARVE_MAX=4
      cpu_pat = 12'b1000_0010_0000;
      dbg_pat = 12'b0101_0101_0101;
      set_dbg(1, 0, 9'h030, 0, 1);
      for (int i = 0; i < 12; i++) begin
         step();
         chk_gl($sformatf("t5_c%0d", i), cpu_pat[i], dbg_pat[i], 1);
         check($sformatf("t5_crv%0d", i), cpu_rvalid, (i > 0) ? cpu_pat[i-1] : 1'b0);
         check($sformatf("t5_drv%0d", i), dbg_rvalid, (i > 0) ? dbg_pat[i-1] : 1'b0);
         if (i > 0 && cpu_pat[i-1]) check($sformatf("t5_crd%0d", i), cpu_rdata, 16'h1111);
         if (i > 0 && dbg_pat[i-1]) check($sformatf("t5_drd%0d", i), dbg_rdata, 16'h2222);
         if (i == 0) set_cpu(1, 0, 9'h020, 0);
      end
      set_cpu(0, 0, 0, 0);
      set_dbg(0, 0, 0, 0, 0);
      step();
      chk_gl("t5_end", 0, 0, 0);
      check("t5_end_crv", cpu_rvalid, 1);
      step();

      // 6: reset between grant and read return
      set_cpu(1, 0, 9'h012, 0);
      step();
      chk_gl("t6_gnt", 1, 0, 0);
      set_cpu(0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("t6_async");
      step();
      check("t6_rst_crv", cpu_rvalid, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("t6_crv%0d", i), cpu_rvalid, 0);
         check($sformatf("t6_crd%0d", i), cpu_rdata, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
